echo_tof_timer: RTL and testbench

ECHO_TOF_TIMER -- requirements
Module: echo_tof_timer

---
 rtl/echo_tof_timer.sv | 87 ++++++++
 tb/tb_echo_tof_timer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/echo_tof_timer.sv
// rtl/echo_tof_timer.sv - ultrasonic echo time-of-flight timer
// Optional echo blanking window enabled by defining ECHO_BLANKING_EN.
module echo_tof_timer #(
    parameter int CNT_W          = 16,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int BLANK_CYCLES   = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             echo,
    output logic [CNT_W-1:0] tof,
    output logic             tof_valid,
    output logic             timeout,
    output logic             busy
);

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_t;

`ifdef ECHO_BLANKING_EN
    localparam bit BLANK_ON = 1'b1;
`else
    localparam bit BLANK_ON = 1'b0;
`endif

    localparam logic [CNT_W-1:0] LAST_K = CNT_W'(TIMEOUT_CYCLES);
    // Without blanking every echo from k = 1 onward is eligible.
    localparam logic [CNT_W-1:0] MIN_K  = BLANK_ON ? CNT_W'(BLANK_CYCLES) : CNT_W'(1);

    state_t           state, state_next;
    logic [CNT_W-1:0] k, k_next;
    logic [CNT_W-1:0] tof_next;
    logic             tof_valid_next;
    logic             timeout_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            k         <= '0;
            tof       <= '0;
            tof_valid <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state     <= state_next;
            k         <= k_next;
            tof       <= tof_next;
            tof_valid <= tof_valid_next;
            timeout   <= timeout_next;
        end
    end

    // k always equals the elapsed cycles since the start pulse of the cycle it is read in.
    always_comb begin
        state_next     = state;
        k_next         = k;
        tof_next       = tof;
        tof_valid_next = 1'b0;
        timeout_next   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = MEASURE;
                    k_next     = CNT_W'(1);
                end
            end
            MEASURE: begin
                if (echo && (k >= MIN_K)) begin
                    state_next     = IDLE;
                    tof_next       = k;
                    tof_valid_next = 1'b1;
                end else if (k == LAST_K) begin
                    state_next   = IDLE;
                    timeout_next = 1'b1;
                end else begin
                    k_next = k + CNT_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state == MEASURE);

endmodule

// File: tb/tb_echo_tof_timer.sv
// tb/tb_echo_tof_timer.sv - scoreboard bench for echo_tof_timer against a cycle-stamped event model
module tb_echo_tof_timer;

    localparam int CNT_W   = 16;
    localparam int TMO     = 100;
    localparam int BLANK   = 10;
`ifdef ECHO_BLANKING_EN
    localparam int MIN_K   = BLANK;
`else
    localparam int MIN_K   = 1;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             echo = 1'b0;
    logic [CNT_W-1:0] tof;
    logic             tof_valid;
    logic             timeout;
    logic             busy;

    echo_tof_timer #(
        .CNT_W(CNT_W),
        .TIMEOUT_CYCLES(TMO),
        .BLANK_CYCLES(BLANK)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .echo(echo),
        .tof(tof),
        .tof_valid(tof_valid),
        .timeout(timeout),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        bit is_timeout;
        int tofv;
    } ev_t;

    typedef struct {
        bit busy;
        int tofv;
    } st_t;

    ev_t ev_q[$];
    st_t st_q[$];

    int  cyc = 0;
    int  n_cmp = 0;
    int  n_bad = 0;
    bit  mon_en = 1'b0;

    // Reference model: a measurement is just "active since cycle t0"
    bit  m_active = 1'b0;
    int  m_t0 = 0;
    int  m_tof = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic step(input bit r, input bit s, input bit e);
        int  kk;
        ev_t ev;
        st_t st;
        rst   = r;
        start = s;
        echo  = e;
        if (r) begin
            m_active = 1'b0;
            m_tof    = 0;
        end else if (!m_active) begin
            if (s) begin
                m_active = 1'b1;
                m_t0     = cyc;
            end
        end else begin
            kk = cyc - m_t0;
            if (e && kk >= MIN_K && kk <= TMO) begin
                m_tof = kk;
                ev.cyc = cyc + 1; ev.is_timeout = 1'b0; ev.tofv = kk;
                ev_q.push_back(ev);
                m_active = 1'b0;
            end else if (kk >= TMO) begin
                ev.cyc = cyc + 1; ev.is_timeout = 1'b1; ev.tofv = m_tof;
                ev_q.push_back(ev);
                m_active = 1'b0;
            end
        end
        st.busy = m_active;
        st.tofv = m_tof;
        st_q.push_back(st);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
    endtask

    always @(negedge clk) begin
        st_t s;
        ev_t e;
        if (mon_en) begin
            if (st_q.size() == 0) begin
                chk("state_queue_empty", 1, 0);
            end else begin
                s = st_q.pop_front();
                chk("busy", int'(busy), int'(s.busy));
                chk("tof", int'(tof), s.tofv);
            end
            chk("strobe_overlap", int'(tof_valid && timeout), 0);
            if (tof_valid || timeout) begin
                if (ev_q.size() == 0) begin
                    chk("unexpected_strobe", 1, 0);
                end else begin
                    e = ev_q.pop_front();
                    chk("event_cycle", cyc, e.cyc);
                    chk("event_is_timeout", int'(timeout), int'(e.is_timeout));
                    chk("event_tof", int'(tof), e.tofv);
                end
            end else if (ev_q.size() > 0 && ev_q[0].cyc <= cyc) begin
                e = ev_q.pop_front();
                chk("missing_strobe_cycle", cyc, e.cyc - 1);
            end
        end
    end

    initial begin
        bit r, s, e;
        mon_en = 1'b1;
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        idle(3);

        // echo after 37 cycles
        step(1'b0, 1'b1, 1'b0); idle(36); step(1'b0, 1'b0, 1'b1); idle(5);
        // no echo: timeout, tof keeps 37
        step(1'b0, 1'b1, 1'b0); idle(110);
        // echo exactly at the timeout limit
        step(1'b0, 1'b1, 1'b0); idle(99); step(1'b0, 1'b0, 1'b1); idle(5);
        // early echo at 5 then 20
        step(1'b0, 1'b1, 1'b0); idle(4); step(1'b0, 1'b0, 1'b1);
        idle(14); step(1'b0, 1'b0, 1'b1); idle(5);
        // restart ignored, reset aborts
        step(1'b0, 1'b1, 1'b1); idle(9); step(1'b0, 1'b1, 1'b0);
        idle(39); step(1'b1, 1'b1, 1'b1); idle(9); step(1'b0, 1'b0, 1'b1); idle(5);
        // back-to-back: start on the tof_valid cycle
        step(1'b0, 1'b1, 1'b0); idle(29); step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0); idle(11); step(1'b0, 1'b0, 1'b1); idle(5);
        // start on the timeout cycle
        step(1'b0, 1'b1, 1'b0); idle(100); step(1'b0, 1'b1, 1'b0); idle(20);
        step(1'b0, 1'b0, 1'b1); idle(3);

        for (int i = 0; i < 20000; i++) begin
            r = ($urandom_range(0, 599) == 0);
            s = ($urandom_range(0, 19) == 0);
            e = ($urandom_range(0, 59) == 0);
            step(r, s, e);
        end
        idle(TMO + 10);
        @(negedge clk);
        #1;
        chk("pending_events", ev_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
